// File: rtl/pe_array_scheduler_pkg.sv
// Shared definitions for the PE array scheduler: array geometry defaults,
// the FSM state encoding and the segment-length clamp helper.
package pe_array_scheduler_pkg;

    localparam int PE_ARRAY_SIZE     = 8;
    localparam int PE_ARRAY_SIZE_LOG = 3;
    localparam int V_E_F_BIT         = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_S = 3'd1,
        ST_LOAD_S = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } sched_state_t;

    // A segment always occupies at least one PE and never more than exist.
    function automatic int unsigned clamp_s_len(input int unsigned len,
                                                input int unsigned pe_n);
        if (len == 0)
            return 1;
        if (len > pe_n)
            return pe_n;
        return len;
    endfunction

endpackage

// File: rtl/pe_drain_counter.sv
// Loadable down-counter that times the pipeline drain; o_tc flags the
// final drain cycle (count of 1).
module pe_drain_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/pe_array_scheduler.sv
// Sequences the systolic PE array for one Smith-Waterman job: fetch S
// segment, load it, stream T with stalls, drain, repeat until the last
// segment, and track the running maximum cell score.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | waiting for i_start_calc
// WAIT_S  | waiting for the data processor to stage an S segment
// LOAD_S  | one-cycle load of S into the array
// STREAM  | feeding T elements; stalls while i_t_avail is low
// DRAIN   | pushing o_pe_len bubbles through the array
// DONE    | one-cycle completion pulse
module pe_array_scheduler
    import pe_array_scheduler_pkg::*;
#(
    parameter int PE_N   = PE_ARRAY_SIZE,
    parameter int PE_LOG = PE_ARRAY_SIZE_LOG,
    parameter int VEF_W  = V_E_F_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start_calc,
    input  logic              i_valid,
    input  logic [PE_LOG:0]   i_init_s_len,
    input  logic              i_s_last,
    output logic              o_init,
    output logic              o_update_s,
    input  logic              i_t_avail,
    input  logic              i_t_last,
    output logic              o_update_t,
    output logic              o_pe_en,
    output logic              o_pe_bubble,
    output logic [PE_LOG:0]   o_pe_len,
    input  logic              i_pe_score_valid,
    input  logic [VEF_W-1:0]  i_pe_score,
    output logic [VEF_W-1:0]  o_max_score,
    output logic              o_busy,
    output logic              o_done
);

    sched_state_t     r_state;
    sched_state_t     w_next;
    logic [PE_LOG:0]  r_pe_len;
    logic             r_seg_last;
    logic [VEF_W-1:0] r_max;
    logic [PE_LOG:0]  w_clamp_len;
    logic             w_drain_load;
    logic             w_drain_dec;
    logic             w_drain_tc;

    assign w_clamp_len = (PE_LOG+1)'(clamp_s_len(32'(i_init_s_len), PE_N));

    pe_drain_counter #(.W(PE_LOG+1)) u_drain_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_drain_load),
        .i_load_val (r_pe_len),
        .i_dec      (w_drain_dec),
        .o_tc       (w_drain_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and output decode; T accept is a zero-cycle AND with i_t_avail.
    always_comb begin
        w_next       = r_state;
        o_init       = 1'b0;
        o_update_s   = 1'b0;
        o_update_t   = 1'b0;
        o_pe_en      = 1'b0;
        o_pe_bubble  = 1'b0;
        o_done       = 1'b0;
        w_drain_load = 1'b0;
        w_drain_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start_calc)
                    w_next = ST_WAIT_S;
            end
            ST_WAIT_S: begin
                if (i_valid) begin
                    o_init = 1'b1;
                    w_next = ST_LOAD_S;
                end
            end
            ST_LOAD_S: begin
                o_update_s = 1'b1;
                w_next     = ST_STREAM;
            end
            ST_STREAM: begin
                o_update_t = i_t_avail;
                o_pe_en    = i_t_avail;
                if (i_t_avail && i_t_last) begin
                    w_drain_load = 1'b1;
                    w_next       = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_pe_en     = 1'b1;
                o_pe_bubble = 1'b1;
                w_drain_dec = 1'b1;
                if (w_drain_tc)
                    w_next = r_seg_last ? ST_DONE : ST_WAIT_S;
            end
            ST_DONE: begin
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Segment attributes captured on the o_init accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pe_len   <= '0;
            r_seg_last <= 1'b0;
        end else if (o_init) begin
            r_pe_len   <= w_clamp_len;
            r_seg_last <= i_s_last;
        end
    end

    // Running max: cleared by an accepted start, updated only while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_max <= '0;
        else if ((r_state == ST_IDLE) && i_start_calc)
            r_max <= '0;
        else if ((r_state != ST_IDLE) && i_pe_score_valid && (i_pe_score > r_max))
            r_max <= i_pe_score;
    end

    assign o_pe_len    = r_pe_len;
    assign o_max_score = r_max;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Self-checking bench for pe_array_scheduler. Jobs are described at the
// transaction level (segments, T lengths, stall pattern, scores); a
// generator expands each job into a per-cycle stimulus/expectation trace
// from the scheduling rules, then the trace is applied and compared.
module tb_pe_array_scheduler;

    localparam int PE_N  = 8;
    localparam int PE_LOG = 3;
    localparam int VEF_W = 16;
    localparam int LW    = PE_LOG + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic i_start_calc, i_valid, i_s_last, i_t_avail, i_t_last, i_pe_score_valid;
    logic [LW-1:0]    i_init_s_len;
    logic [VEF_W-1:0] i_pe_score;
    logic o_init, o_update_s, o_update_t, o_pe_en, o_pe_bubble, o_busy, o_done;
    logic [LW-1:0]    o_pe_len;
    logic [VEF_W-1:0] o_max_score;

    always #5 clk = ~clk;

    pe_array_scheduler #(.PE_N(PE_N), .PE_LOG(PE_LOG), .VEF_W(VEF_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start_calc     (i_start_calc),
        .i_valid          (i_valid),
        .i_init_s_len     (i_init_s_len),
        .i_s_last         (i_s_last),
        .o_init           (o_init),
        .o_update_s       (o_update_s),
        .i_t_avail        (i_t_avail),
        .i_t_last         (i_t_last),
        .o_update_t       (o_update_t),
        .o_pe_en          (o_pe_en),
        .o_pe_bubble      (o_pe_bubble),
        .o_pe_len         (o_pe_len),
        .i_pe_score_valid (i_pe_score_valid),
        .i_pe_score       (i_pe_score),
        .o_max_score      (o_max_score),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    typedef struct packed {
        logic start, valid;
        logic [LW-1:0] s_len;
        logic s_last, t_avail, t_last, sc_v;
        logic [VEF_W-1:0] sc;
    } stim_t;

    typedef struct packed {
        logic init, upd_s, upd_t, pe_en, bubble, busy, done;
        logic [LW-1:0] pe_len;
        logic [VEF_W-1:0] max;
    } obs_t;

    typedef struct {
        string name;
        int nseg, l0, l1, t0, t1;
        int apat_n;
        logic [7:0] apat;
        bit scores;
        int e_init, e_upds, e_updt, e_bub, e_done, e_ofs, e_max;
    } vec_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    avail_q[$];
    int    sc_q[$];
    int    n_pass = 0, n_chk = 0;
    int    m_pe_len = 0, m_max = 0;
    bit    quiet;
    int    c_init, c_upds, c_updt, c_bub, c_done, first_v, done_idx, last_max;

    function automatic int clampm(input int l);
        return (l < 1) ? 1 : ((l > PE_N) ? PE_N : l);
    endfunction

    function automatic stim_t junk();
        stim_t s;
        s = '0;
        if (!quiet) begin
            s.start   = 1'($urandom_range(1));
            s.valid   = 1'($urandom_range(1));
            s.s_len   = LW'($urandom);
            s.s_last  = 1'($urandom_range(1));
            s.t_avail = 1'($urandom_range(1));
            s.t_last  = 1'($urandom_range(1));
            s.sc_v    = 1'($urandom_range(1));
            s.sc      = VEF_W'($urandom);
        end
        return s;
    endfunction

    function automatic stim_t take_sc(input stim_t s_in);
        stim_t s;
        int v;
        s = s_in;
        if (sc_q.size() > 0) begin
            v      = sc_q.pop_front();
            s.sc_v = (v >= 0);
            s.sc   = VEF_W'((v < 0) ? -v : v);
        end
        return s;
    endfunction

    // Record one cycle: expected outputs before the edge, then advance the model.
    task automatic emit(input stim_t s, input logic init, upd_s, upd_t, en, bub, busy, done);
        obs_t e;
        e = {init, upd_s, upd_t, en, bub, busy, done, LW'(m_pe_len), VEF_W'(m_max)};
        stim_q.push_back(s);
        exp_q.push_back(e);
        if (!busy && s.start) m_max = 0;
        if (busy && s.sc_v && int'(s.sc) > m_max) m_max = int'(s.sc);
        if (init) m_pe_len = clampm(int'(s.s_len));
    endtask

    task automatic idle_cycle();
        stim_t s;
        s = junk();
        s.start = 1'b0;
        emit(s, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic gen_job(input int nseg, input int lens[3], input int tl[3], input int stall_pct,
                           input int pre_idle, input int max_gap, input int post_idle);
        stim_t s;
        int rem;
        repeat (pre_idle) idle_cycle();
        s = junk();
        s.start = 1'b1;
        if (quiet) s.valid = 1'b1;
        emit(s, 0, 0, 0, 0, 0, 0, 0);
        for (int g = 0; g < nseg; g++) begin
            repeat ((max_gap > 0) ? $urandom_range(max_gap) : 0) begin
                s = take_sc(junk());
                s.valid = 1'b0;
                emit(s, 0, 0, 0, 0, 0, 1, 0);
            end
            s = take_sc(junk());
            s.valid  = 1'b1;
            s.s_len  = LW'(lens[g]);
            s.s_last = (g == nseg - 1);
            emit(s, 1, 0, 0, 0, 0, 1, 0);
            s = take_sc(junk());
            emit(s, 0, 1, 0, 0, 0, 1, 0);
            rem = tl[g];
            while (rem > 0) begin
                s = take_sc(junk());
                if (avail_q.size() > 0) s.t_avail = (avail_q.pop_front() != 0);
                else                    s.t_avail = ($urandom_range(99) >= stall_pct);
                if (s.t_avail) begin
                    s.t_last = (rem == 1);
                    rem--;
                end
                emit(s, 0, 0, s.t_avail, s.t_avail, 0, 1, 0);
            end
            repeat (clampm(lens[g])) begin
                s = take_sc(junk());
                emit(s, 0, 0, 0, 1, 1, 1, 0);
            end
        end
        s = take_sc(junk());
        emit(s, 0, 0, 0, 0, 0, 1, 1);
        repeat (post_idle) idle_cycle();
    endtask

    // Drive up to lim queued cycles (lim<0: all), compare, then clear the queues.
    task automatic apply_q(input int lim);
        stim_t s;
        obs_t e, a;
        int n;
        c_init = 0; c_upds = 0; c_updt = 0; c_bub = 0; c_done = 0;
        first_v = -1; done_idx = -1;
        n = (lim < 0 || lim > stim_q.size()) ? stim_q.size() : lim;
        for (int i = 0; i < n; i++) begin
            s = stim_q[i];
            e = exp_q[i];
            @(negedge clk);
            i_start_calc = s.start;  i_valid = s.valid;     i_init_s_len = s.s_len;
            i_s_last     = s.s_last; i_t_avail = s.t_avail; i_t_last = s.t_last;
            i_pe_score_valid = s.sc_v; i_pe_score = s.sc;
            #1;
            a = {o_init, o_update_s, o_update_t, o_pe_en, o_pe_bubble, o_busy, o_done,
                 o_pe_len, o_max_score};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL trace cycle=%0d got=%h want=%h (init,upd_s,upd_t,en,bub,busy,done,len,max)",
                          i, a, e);
            c_init += int'(o_init); c_upds += int'(o_update_s); c_updt += int'(o_update_t);
            c_bub  += int'(o_pe_bubble); c_done += int'(o_done);
            if (s.valid && first_v < 0) first_v = i;
            if (o_done) done_idx = i;
        end
        last_max = int'(o_max_score);
        stim_q.delete();
        exp_q.delete();
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", nm, got, want);
    endtask

    vec_t tv[7];
    int   ldz[3], tlz[3];

    initial begin
        //            name      nseg l0 l1 t0 t1 apn apat    sc  init upds updt bub done ofs max
        tv[0] = '{"single",    1,   8, 0, 5, 0, 0, 8'h00,  0,  1,   1,   5,   8,  1,   16, 0};
        tv[1] = '{"stall",     1,   4, 0, 3, 0, 5, 8'h19,  0,  1,   1,   3,   4,  1,   12, 0};
        tv[2] = '{"multi",     2,   8, 3, 2, 2, 0, 8'h00,  0,  2,   2,   4,  11,  1,   20, 0};
        tv[3] = '{"clamp0",    1,   0, 0, 1, 0, 0, 8'h00,  0,  1,   1,   1,   1,  1,    5, 0};
        tv[4] = '{"clamp9",    1,   9, 0, 1, 0, 0, 8'h00,  0,  1,   1,   1,   8,  1,   12, 0};
        tv[5] = '{"maxscore",  1,   2, 0, 3, 0, 0, 8'h00,  1,  1,   1,   3,   2,  1,    8, 12};
        tv[6] = '{"maxclear",  1,   1, 0, 1, 0, 0, 8'h00,  0,  1,   1,   1,   1,  1,    5, 0};

        rst_n = 1'b0;
        i_start_calc = 0; i_valid = 0; i_init_s_len = '0; i_s_last = 0;
        i_t_avail = 0; i_t_last = 0; i_pe_score_valid = 0; i_pe_score = '0;
        #12;
        chk("reset_outputs", int'({o_init, o_update_s, o_update_t, o_pe_en, o_pe_bubble, o_busy, o_done}), 0);
        chk("reset_pe_len", int'(o_pe_len), 0);
        chk("reset_max", int'(o_max_score), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed jobs from the table.
        quiet = 1;
        foreach (tv[k]) begin
            for (int b = 0; b < tv[k].apat_n; b++) avail_q.push_back(int'(tv[k].apat[b]));
            if (tv[k].scores) begin
                sc_q.push_back(5); sc_q.push_back(12); sc_q.push_back(7); sc_q.push_back(-99);
            end
            ldz = '{tv[k].l0, tv[k].l1, 0};
            tlz = '{tv[k].t0, tv[k].t1, 0};
            gen_job(tv[k].nseg, ldz, tlz, 0, 1, 0, 1);
            apply_q(-1);
            chk({tv[k].name, "_init"}, c_init, tv[k].e_init);
            chk({tv[k].name, "_upd_s"}, c_upds, tv[k].e_upds);
            chk({tv[k].name, "_upd_t"}, c_updt, tv[k].e_updt);
            chk({tv[k].name, "_bubbles"}, c_bub, tv[k].e_bub);
            chk({tv[k].name, "_done"}, c_done, tv[k].e_done);
            chk({tv[k].name, "_done_ofs"}, done_idx - first_v, tv[k].e_ofs);
            chk({tv[k].name, "_max"}, last_max, tv[k].e_max);
        end

        // Reset in the middle of STREAM with a nonzero max.
        sc_q.push_back(33);
        ldz = '{8, 0, 0};
        tlz = '{20, 0, 0};
        gen_job(1, ldz, tlz, 0, 1, 0, 0);
        apply_q(6);
        chk("pre_reset_max", int'(o_max_score), 33);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", int'({o_init, o_update_s, o_update_t, o_pe_en, o_pe_bubble, o_busy, o_done}), 0);
        chk("midrst_pe_len", int'(o_pe_len), 0);
        chk("midrst_max", int'(o_max_score), 0);
        c_done = 0;
        repeat (3) begin
            @(negedge clk);
            c_done += int'(o_done) + int'(o_busy);
        end
        chk("midrst_no_done", c_done, 0);
        rst_n = 1'b1;
        m_pe_len = 0;
        m_max = 0;
        ldz = '{3, 0, 0};
        tlz = '{2, 0, 0};
        gen_job(1, ldz, tlz, 0, 1, 0, 1);
        apply_q(-1);
        chk("post_reset_done", c_done, 1);
        chk("post_reset_bubbles", c_bub, 3);

        // Randomized jobs with junk on ignored inputs and random stalls.
        quiet = 0;
        for (int j = 0; j < 40; j++) begin
            ldz = '{$urandom_range(12), $urandom_range(12), $urandom_range(12)};
            tlz = '{$urandom_range(6, 1), $urandom_range(6, 1), $urandom_range(6, 1)};
            gen_job($urandom_range(3, 1), ldz, tlz, 30, $urandom_range(3), 2, 0);
        end
        idle_cycle();
        apply_q(-1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
